// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit
// ----------------------------------------------------------------------------
// Fetch stage of the single-cycle MIPS core.
//
// This block does the following:
//   - Owns the PC register.
//   - Requests instruction words from instruction memory using a req/ack
//     handshake.
//   - Holds the fetched instruction steady while it executes.
//   - Computes the next PC from the decoder's PCSrc/Branch outputs and the
//     ALU Zero flag.
//   - Counts retired instructions.
//   - Traps jump/branch targets that are not word-aligned. This applies
//     mainly to jr/jalr.
//
// Parameters
//   PC_RESET    PC value loaded on reset. Must be word-aligned.
//
// Ports
//   clk         core clock; all state updates on the rising edge
//   reset       asynchronous, active-low reset
//   imem_req    instruction-memory request (high only while fetching)
//   imem_addr   fetch address, always equal to PC
//   imem_ack    memory presents a valid imem_rdata this cycle
//   imem_rdata  instruction word from memory
//   Instruction latched instruction
//   OpCode      Instruction[31:26]
//   Funct       Instruction[5:0]
//   inst_valid  Instruction is executing this cycle
//   PC          address of the current instruction
//   PC_plus_4   PC + 4, also used as the jal/jalr link value
//   PCSrc       00 seq/branch, 01 j/jal, 10 jr/jalr, 11 same as 00
//   Branch      beq decoded
//   Zero        ALU zero flag
//   Databus_A   rs value, used as the jr/jalr target
//   hold        stretch the current execute cycle
//   retired     committed-instruction count
//   addr_err    sticky misaligned-target flag
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [5:0]  OpCode,
    output logic [5:0]  Funct,
    output logic        inst_valid,
    output logic [31:0] PC,
    output logic [31:0] PC_plus_4,
    input  logic [1:0]  PCSrc,
    input  logic        Branch,
    input  logic        Zero,
    input  logic [31:0] Databus_A,
    input  logic        hold,
    output logic [31:0] retired,
    output logic        addr_err
);

    // FSM encoding. IDLE is only reachable through reset.
    // ERR is only left through reset.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] ERR   = 2'd3;

    // PCSrc encodings. 2'b11 is deliberately treated as sequential/branch.
    localparam logic [1:0] PCSRC_JUMP = 2'b01;
    localparam logic [1:0] PCSRC_JR   = 2'b10;

    logic [1:0]  state_q,    state_d;
    logic [31:0] pcQ_unused;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] retired_q,  retired_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] next_pc;
    logic        next_pc_aligned;

    // Sequential PC. All PC arithmetic is modulo 2^32, so 32'hFFFF_FFFC
    // wraps to zero without any special handling.
    assign pc_plus4 = pc_q + 32'd4;

    // Pseudo-direct jump target.
    // The upper nibble comes from PC+4; the low 28 bits come from the
    // 26-bit field, shifted to a word address.
    assign jump_target = {pc_plus4[31:28], instr_q[25:0], 2'b00};

    // Branch target. The 16-bit immediate is sign-extended and scaled to
    // bytes, then added to PC+4. This is the MIPS delay-slot-free form.
    assign branch_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign branch_target = pc_plus4 + branch_offset;

    // Next-PC selection.
    // This is purely combinational from the latched instruction and the
    // decoder/ALU inputs. It only matters on the EXEC edge with hold low.
    always_comb begin
        next_pc = pc_plus4;
        case (PCSrc)
            PCSRC_JUMP: next_pc = jump_target;
            PCSRC_JR:   next_pc = Databus_A;
            default: begin
                if (Branch && Zero) begin
                    next_pc = branch_target;
                end else begin
                    next_pc = pc_plus4;
                end
            end
        endcase
    end

    // Only a register target (jr/jalr) can actually be misaligned.
    // Checking the selected value still covers every path uniformly.
    assign next_pc_aligned = (next_pc[1:0] == 2'b00);

    // Next-state logic.
    // Every register holds its value by default, so a hold cycle in EXEC
    // or a wait cycle in FETCH simply falls through.
    // A faulting instruction leaves PC and retired untouched. Software
    // therefore sees the address of the offending jr/jalr.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        retired_d  = retired_q;
        addr_err_d = addr_err_q;
        pcQ_unused = '0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end

            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end

            EXEC: begin
                if (!hold) begin
                    if (next_pc_aligned) begin
                        pc_d      = next_pc;
                        retired_d = retired_q + 32'd1;
                        state_d   = FETCH;
                    end else begin
                        addr_err_d = 1'b1;
                        state_d    = ERR;
                    end
                end
            end

            ERR: begin
                state_d = ERR;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers.
    // The asynchronous reset discards any in-flight ack immediately,
    // because the instruction latch and the FSM both clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= PC_RESET;
            instr_q    <= '0;
            retired_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            retired_q  <= retired_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Outputs are decoded from registered state only.
    // imem_req therefore drops in the cycle after an accepted ack.
    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign inst_valid  = (state_q == EXEC);
    assign Instruction = instr_q;
    assign OpCode      = instr_q[31:26];
    assign Funct       = instr_q[5:0];
    assign PC          = pc_q;
    assign PC_plus_4   = pc_plus4;
    assign retired     = retired_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit
// ----------------------------------------------------------------------------
// Directed testbench for instr_fetch_unit.
//
// The bench acts as both instruction memory and decoder:
//   - It answers fetches with hand-chosen instruction words.
//   - It drives PCSrc/Branch/Zero/Databus_A for each instruction.
//
// Expected addresses and counts are fixed constants in the stimulus
// sequence below.
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] PC_RESET = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] BEQ_BACK = 32'h1000_FFFF;
    localparam logic [31:0] J_SELF   = 32'h0810_0008;
    localparam logic [31:0] JR_RA    = 32'h03E0_0008;
    localparam logic [31:0] ADD_INS  = 32'h012A_4020;
    localparam logic [31:0] LW_INS   = 32'h8C88_0004;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic        inst_valid;
    logic [31:0] PC;
    logic [31:0] PC_plus_4;
    logic [1:0]  PCSrc;
    logic        Branch;
    logic        Zero;
    logic [31:0] Databus_A;
    logic        hold;
    logic [31:0] retired;
    logic        addr_err;

    int testsRun;
    int testsFailed;

    instr_fetch_unit #(.PC_RESET(PC_RESET)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .Instruction (Instruction),
        .OpCode      (OpCode),
        .Funct       (Funct),
        .inst_valid  (inst_valid),
        .PC          (PC),
        .PC_plus_4   (PC_plus_4),
        .PCSrc       (PCSrc),
        .Branch      (Branch),
        .Zero        (Zero),
        .Databus_A   (Databus_A),
        .hold        (hold),
        .retired     (retired),
        .addr_err    (addr_err)
    );

    // 10-time-unit clock. Rising edges fall at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point.
    // It counts every check and reports each mismatch with its tag.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Every output the fetch unit must show while reset is applied.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, " imem_req"},    {31'd0, imem_req},   32'd0);
        checkOutput({tag, " inst_valid"},  {31'd0, inst_valid}, 32'd0);
        checkOutput({tag, " addr_err"},    {31'd0, addr_err},   32'd0);
        checkOutput({tag, " PC"},          PC,                  PC_RESET);
        checkOutput({tag, " PC_plus_4"},   PC_plus_4,           32'h0040_0004);
        checkOutput({tag, " Instruction"}, Instruction,         32'd0);
        checkOutput({tag, " OpCode"},      {26'd0, OpCode},     32'd0);
        checkOutput({tag, " Funct"},       {26'd0, Funct},      32'd0);
        checkOutput({tag, " retired"},     retired,             32'd0);
    endtask

    // Serves one fetch.
    // Entry: the negedge of a FETCH cycle.
    // Exit:  the negedge of the first EXEC cycle.
    // The address must stay stable through any wait cycles.
    task automatic fetchInstr(input logic [31:0] expAddr, input logic [31:0] word,
                              input int waitCycles);
        checkOutput("fetch imem_req",  {31'd0, imem_req}, 32'd1);
        checkOutput("fetch imem_addr", imem_addr, expAddr);
        for (int i = 0; i < waitCycles; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            checkOutput("wait imem_req",   {31'd0, imem_req},   32'd1);
            checkOutput("wait imem_addr",  imem_addr,           expAddr);
            checkOutput("wait inst_valid", {31'd0, inst_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        checkOutput("exec imem_req",    {31'd0, imem_req},   32'd0);
        checkOutput("exec inst_valid",  {31'd0, inst_valid}, 32'd1);
        checkOutput("exec Instruction", Instruction,         word);
        checkOutput("exec OpCode",      {26'd0, OpCode},     {26'd0, word[31:26]});
        checkOutput("exec Funct",       {26'd0, Funct},      {26'd0, word[5:0]});
        checkOutput("exec PC",          PC,                  expAddr);
        checkOutput("exec PC_plus_4",   PC_plus_4,           expAddr + 32'd4);
    endtask

    // Drives decoder/ALU inputs for one EXEC period.
    // During hold cycles a stray ack with a different word is presented.
    // The latched instruction must ignore it.
    task automatic execInstr(input logic [1:0] pcSrc, input logic br, input logic zero,
                             input logic [31:0] dbA, input int holdCycles,
                             input logic [31:0] word, input logic [31:0] retiredBefore);
        PCSrc     = pcSrc;
        Branch    = br;
        Zero      = zero;
        Databus_A = dbA;
        for (int i = 0; i < holdCycles; i++) begin
            hold       = 1'b1;
            imem_ack   = 1'b1;
            imem_rdata = 32'hBAD0_BAD0;
            @(negedge clk);
            checkOutput("hold inst_valid",  {31'd0, inst_valid}, 32'd1);
            checkOutput("hold Instruction", Instruction,         word);
            checkOutput("hold retired",     retired,             retiredBefore);
            checkOutput("hold imem_req",    {31'd0, imem_req},   32'd0);
        end
        hold     = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        PCSrc     = 2'b00;
        Branch    = 1'b0;
        Zero      = 1'b0;
        Databus_A = 32'd0;
    endtask

    // One full sequential instruction.
    // It checks the retire count after the EXEC edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] word,
                                 input logic [1:0] pcSrc, input logic br, input logic zero,
                                 input logic [31:0] dbA, input logic [31:0] retiredBefore);
        fetchInstr(addr, word, 0);
        execInstr(pcSrc, br, zero, dbA, 0, word, retiredBefore);
        checkOutput("retire count", retired, retiredBefore + 32'd1);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        PCSrc       = 2'b00;
        Branch      = 1'b0;
        Zero        = 1'b0;
        Databus_A   = 32'd0;
        hold        = 1'b0;

        // Reset state, then one IDLE cycle before the first request.
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b1;
        #1;
        checkOutput("idle imem_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);

        // Three sequential nops, two cycles each, then a fourth nop to
        // reach the branch.
        applyStimulus(32'h0040_0000, NOP, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(32'h0040_0004, NOP, 2'b00, 1'b0, 1'b0, 32'd0, 32'd1);
        applyStimulus(32'h0040_0008, NOP, 2'b00, 1'b0, 1'b0, 32'd0, 32'd2);
        checkOutput("three nops retired", retired, 32'd3);
        applyStimulus(32'h0040_000C, NOP, 2'b00, 1'b0, 1'b0, 32'd0, 32'd3);

        // beq with offset -1 word.
        // Taken: it loops to itself. Not taken: it falls through.
        applyStimulus(32'h0040_0010, BEQ_BACK, 2'b00, 1'b1, 1'b1, 32'd0, 32'd4);
        applyStimulus(32'h0040_0010, BEQ_BACK, 2'b00, 1'b1, 1'b0, 32'd0, 32'd5);
        // PCSrc 11 with Branch set but Zero clear behaves as sequential.
        applyStimulus(32'h0040_0014, NOP, 2'b11, 1'b1, 1'b0, 32'd0, 32'd6);
        applyStimulus(32'h0040_0018, NOP, 2'b00, 1'b0, 1'b0, 32'd0, 32'd7);
        applyStimulus(32'h0040_001C, NOP, 2'b00, 1'b0, 1'b0, 32'd0, 32'd8);

        // j whose target field points back at itself.
        applyStimulus(32'h0040_0020, J_SELF, 2'b01, 1'b0, 1'b0, 32'd0, 32'd9);

        // Slow memory (3 wait cycles) and 2 hold cycles.
        // inst_valid is high for three cycles and the instruction retires
        // once.
        fetchInstr(32'h0040_0020, NOP, 3);
        execInstr(2'b00, 1'b0, 1'b0, 32'd0, 2, NOP, 32'd10);
        checkOutput("held retire", retired, 32'd11);

        // jr to the top word, then a nop there whose PC+4 wraps to zero.
        applyStimulus(32'h0040_0024, JR_RA, 2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'd11);
        fetchInstr(32'hFFFF_FFFC, NOP, 0);
        checkOutput("wrap PC_plus_4", PC_plus_4, 32'd0);
        execInstr(2'b00, 1'b0, 1'b0, 32'd0, 0, NOP, 32'd12);

        // Misaligned jr at address 0: trap into ERR without retiring.
        fetchInstr(32'h0000_0000, JR_RA, 0);
        execInstr(2'b10, 1'b0, 1'b0, 32'h0040_0102, 0, JR_RA, 32'd13);
        checkOutput("err addr_err",   {31'd0, addr_err},   32'd1);
        checkOutput("err imem_req",   {31'd0, imem_req},   32'd0);
        checkOutput("err inst_valid", {31'd0, inst_valid}, 32'd0);
        checkOutput("err PC",         PC,                  32'd0);
        checkOutput("err retired",    retired,             32'd13);

        // ERR is sticky and ignores acks.
        imem_ack   = 1'b1;
        imem_rdata = LW_INS;
        repeat (3) @(negedge clk);
        imem_ack   = 1'b0;
        checkOutput("err sticky addr_err", {31'd0, addr_err},   32'd1);
        checkOutput("err sticky imem_req", {31'd0, imem_req},   32'd0);
        checkOutput("err Instruction",     Instruction,         JR_RA);

        // Reset clears the fault.
        reset = 1'b0;
        #1;
        checkResetValues("err reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset mid-FETCH with ack high: everything clears at once and the
        // ack is dropped.
        applyStimulus(PC_RESET, ADD_INS, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("pre-abort imem_addr", imem_addr, 32'h0040_0004);
        imem_ack   = 1'b1;
        imem_rdata = LW_INS;
        #2;
        reset = 1'b0;
        #1;
        checkResetValues("async reset");
        @(negedge clk);
        checkOutput("reset ack dropped", Instruction, 32'd0);
        imem_ack = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        applyStimulus(PC_RESET, LW_INS, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the single-cycle MIPS core: owns the PC register, issues instruction-memory requests over a req/ack handshake, and presents the latched instruction (plus OpCode/Funct slices) to the control decoder and datapath. It consumes the decoder's PCSrc/Branch outputs and the ALU Zero flag to compute the next PC. It also keeps a retired-instruction counter and traps misaligned jump-register targets.

## Interface
- PC_RESET, 32'h0040_0000, PC value loaded on reset; must be word-aligned.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  fetch address; equals PC.
- imem_ack  in  1  memory has valid imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- Instruction  out  32  latched instruction.
- OpCode  out  6  Instruction[31:26].
- Funct  out  6  Instruction[5:0].
- inst_valid  out  1  Instruction is executing this cycle.
- PC  out  32  address of the current instruction.
- PC_plus_4  out  32  PC+4; feeds the jal/jalr link-write path.
- PCSrc  in  2  00 sequential/branch, 01 j/jal, 10 jr/jalr, 11 treated as 00.
- Branch  in  1  beq decoded.
- Zero  in  1  ALU zero flag.
- Databus_A  in  32  rs value; jr/jalr target.
- hold  in  1  extend the current execute cycle (e.g. data-memory busy).
- retired  out  32  committed-instruction count.
- addr_err  out  1  sticky misaligned-target flag.

## Operation
- FSM states: IDLE, FETCH, EXEC, ERR.
- IDLE: entered only from reset; moves to FETCH on the next edge.
- FETCH: imem_req=1, imem_addr=PC, held stable until ack. On an edge with imem_ack=1: Instruction<=imem_rdata, go to EXEC. imem_ack outside FETCH is ignored.
- EXEC: inst_valid=1. next_pc is combinational:
  - PCSrc==01: {PC_plus_4[31:28], Instruction[25:0], 2'b00}.
  - PCSrc==10: Databus_A.
  - Else, if Branch&Zero: PC_plus_4 + (signext(Instruction[15:0])<<2).
  - Else: PC_plus_4.
- EXEC edge with hold=1: all state held; inst_valid stays 1.
- EXEC edge with hold=0 and next_pc[1:0]==0: PC<=next_pc, retired<=retired+1, go to FETCH.
- EXEC edge with hold=0 and next_pc[1:0]!=0: go to ERR, addr_err<=1. PC and retired are unchanged; the faulting instruction does not retire.
- ERR: imem_req=0, inst_valid=0. Only reset exits ERR.
- Arithmetic: all PC math is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. retired wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values: PC=PC_RESET, state=IDLE, Instruction=0, imem_req=0, inst_valid=0, retired=0, addr_err=0. Therefore OpCode=0, Funct=0, PC_plus_4=PC_RESET+4.
- Reset asserted at any time, including mid-FETCH with an ack pending, returns all state to reset values immediately. Any in-flight ack is dropped.
- Minimum 2 cycles per instruction: one FETCH cycle with ack, plus one EXEC cycle. Each FETCH wait cycle and each hold cycle adds one cycle.
- Instruction, OpCode and Funct are stable for the whole EXEC period. They change only on the FETCH->EXEC edge.
- imem_req deasserts in the cycle after the accepted ack (state is EXEC).

## Test plan
- Reset release, ack immediate, three sequential nops: fetch addresses 0x00400000, 0x00400004, 0x00400008; retired=3 after the third EXEC; 2 cycles per instruction.
- beq at 0x00400010, imm=16'hFFFF, Branch=1, Zero=1: next fetch at 0x00400010. With Zero=0: next fetch at 0x00400014.
- j at 0x00400020, target field 26'h0100008: next PC=0x00400020; PC_plus_4=0x00400024 during EXEC.
- jr with Databus_A=0x00400102: addr_err=1, state ERR, imem_req=0, PC unchanged, retired unchanged. Reset clears the fault.
- imem_ack delayed 3 cycles and hold=1 for 2 EXEC cycles: imem_addr stable through the wait; inst_valid=1 for 3 cycles; instruction retires once.
- Reset asserted mid-FETCH while ack is high: outputs immediately equal reset values; after release, the first fetch is PC_RESET.
